// File: rtl/spi_tx_arb.sv
// Round-robin arbiter/sequencer sharing one SPI transmitter among NREQ requesters.
// Define SPI_ARB_TIMEOUT_EN to build in the done-handshake watchdog (err output).
module spi_tx_arb #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned GAP_CYC     = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [16*NREQ-1:0] req_data,
    input  logic [NREQ-1:0]   req_w8,
    input  logic [NREQ-1:0]   req_pos,
    output logic [NREQ-1:0]   ack,
    output logic              busy,
    output logic              err,
    output logic [15:0]       tx_data,
    output logic              width8,
    output logic              pos_edge,
    output logic              wrt,
    input  logic              done
);

    localparam int unsigned PtrW = $clog2(NREQ);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWaitStart,
        StWaitDone,
        StGap
    } state_e;

    state_e          state_q;
    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] grant_q;
    logic [7:0]      gap_q;

    logic [15:0]     words [NREQ];
    logic [PtrW-1:0] sel;
    logic            found;

    for (genvar g = 0; g < NREQ; g++) begin : g_words
        assign words[g] = req_data[16*g +: 16];
    end

    // First set request at or after ptr, searching upward with wrap.
    always_comb begin
        int unsigned     idx;
        logic [PtrW-1:0] cand;
        found = 1'b0;
        sel   = ptr_q;
        idx   = 0;
        cand  = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            cand = PtrW'(idx);
            if (!found && req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int unsigned WdW = $clog2(TIMEOUT_CYC + 1);
    logic [WdW-1:0] wd_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            grant_q  <= '0;
            gap_q    <= '0;
            ack      <= '0;
            busy     <= 1'b0;
            wrt      <= 1'b0;
            tx_data  <= 16'h0000;
            width8   <= 1'b0;
            pos_edge <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
            err      <= 1'b0;
            wd_q     <= '0;
`endif
        end else begin
            wrt <= 1'b0;
            ack <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state_q)
                StIdle: begin
                    if (found) begin
                        tx_data  <= words[sel];
                        width8   <= req_w8[sel];
                        pos_edge <= req_pos[sel];
                        grant_q  <= sel;
                        busy     <= 1'b1;
                        state_q  <= StLoad;
`ifdef SPI_ARB_TIMEOUT_EN
                        wd_q     <= '0;
`endif
                    end
                end
                StLoad: begin
                    wrt     <= 1'b1;
                    state_q <= StWaitStart;
                end
                StWaitStart: begin
                    if (!done) begin
                        state_q <= StWaitDone;
                    end
                end
                StWaitDone: begin
                    if (done) begin
                        ack[grant_q] <= 1'b1;
                        if (grant_q == PtrW'(NREQ - 1)) begin
                            ptr_q <= '0;
                        end else begin
                            ptr_q <= grant_q + PtrW'(1);
                        end
                        gap_q   <= 8'(GAP_CYC - 1);
                        state_q <= StGap;
                    end
                end
                StGap: begin
                    if (gap_q == 8'd0) begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
`ifdef SPI_ARB_TIMEOUT_EN
            // Abort overrides the waiting states unless the frame completes this cycle.
            if ((state_q == StWaitStart) || (state_q == StWaitDone && !done)) begin
                if (wd_q == WdW'(TIMEOUT_CYC - 1)) begin
                    err     <= 1'b1;
                    gap_q   <= 8'(GAP_CYC - 1);
                    state_q <= StGap;
                end else begin
                    wd_q <= wd_q + WdW'(1);
                end
            end
`endif
        end
    end

`ifndef SPI_ARB_TIMEOUT_EN
    // TIMEOUT_CYC only matters when the watchdog is built in.
    assign err = (TIMEOUT_CYC == 0) && 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_arb.sv
// Directed self-checking bench for spi_tx_arb with a bit-serial transmitter model.
module tb_spi_tx_arb;

    localparam int unsigned NREQ = 4;
    localparam int unsigned GAP  = 8;
    localparam int unsigned TMO  = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req, req_w8, req_pos;
    logic [63:0] req_data;
    logic [3:0]  ack;
    logic        busy, err, width8, pos_edge, wrt, done;
    logic [15:0] tx_data;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic        force_low = 1'b0;
    logic [15:0] last_frame;
    int          frames_done = 0;

    spi_tx_arb #(
        .NREQ        (NREQ),
        .GAP_CYC     (GAP),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .req_w8   (req_w8),
        .req_pos  (req_pos),
        .ack      (ack),
        .busy     (busy),
        .err      (err),
        .tx_data  (tx_data),
        .width8   (width8),
        .pos_edge (pos_edge),
        .wrt      (wrt),
        .done     (done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: shifts the frame MSB-first, one bit per clk, done low meanwhile.
    initial begin : xmtr
        logic [15:0] sh, fr;
        int nb;
        done       = 1'b1;
        last_frame = '0;
        forever begin
            @(negedge clk);
            if (force_low) begin
                done = 1'b0;
            end else if (wrt) begin
                nb   = width8 ? 8 : 16;
                sh   = width8 ? {tx_data[7:0], 8'h00} : tx_data;
                fr   = '0;
                done = 1'b0;
                for (int b = 0; b < nb; b++) begin
                    @(negedge clk);
                    fr = {fr[14:0], sh[15]};
                    sh = {sh[14:0], 1'b0};
                end
                last_frame  = fr;
                frames_done = frames_done + 1;
                done        = 1'b1;
            end else begin
                done = 1'b1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int limit, output logic [3:0] a, output bit ok);
        ok = 1'b0;
        a  = '0;
        repeat (limit) begin
            @(negedge clk);
            if (|ack) begin
                a  = ack;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int limit);
        repeat (limit) begin
            if (!busy && done) break;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (wrt !== 1'b0) begin miscompares++; $display("FAIL reset_wrt: got %b want 0", wrt); end
        vectors++; if (ack !== 4'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0000", ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", err); end
        vectors++; if (tx_data !== 16'h0000) begin miscompares++; $display("FAIL reset_tx_data: got %h want 0000", tx_data); end
        vectors++; if ({width8, pos_edge} !== 2'b00) begin miscompares++; $display("FAIL reset_w8_pos: got %b want 00", {width8, pos_edge}); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] a;
        bit ok;
        int nw, n;
        req_data[15:0] = 16'hABCD; req_w8 = 4'b0000; req_pos = 4'b0001; req = 4'b0001;
        @(negedge clk);
        vectors++; if (tx_data !== 16'hABCD) begin miscompares++; $display("FAIL single_tx_data: got %h want abcd", tx_data); end
        vectors++; if (pos_edge !== 1'b1) begin miscompares++; $display("FAIL single_pos_edge: got %b want 1", pos_edge); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        vectors++; if (wrt !== 1'b0) begin miscompares++; $display("FAIL single_wrt_early: got %b want 0", wrt); end
        @(negedge clk);
        vectors++; if (wrt !== 1'b1) begin miscompares++; $display("FAIL single_wrt: got %b want 1", wrt); end
        nw = 1;
        ok = 1'b0; a = '0;
        repeat (200) begin
            @(negedge clk);
            if (wrt) nw++;
            if (|ack) begin a = ack; ok = 1'b1; break; end
        end
        req = 4'b0000;
        vectors++; if (!ok || a !== 4'b0001) begin miscompares++; $display("FAIL single_ack: got %b want 0001", a); end
        vectors++; if (last_frame !== 16'hABCD) begin miscompares++; $display("FAIL single_frame: got %h want abcd", last_frame); end
        @(negedge clk);
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL single_ack_pulse: got %b want 0000", ack); end
        n = 1;
        repeat (50) begin
            if (!busy) break;
            @(negedge clk);
            if (wrt) nw++;
            n++;
        end
        vectors++; if (n !== GAP) begin miscompares++; $display("FAIL single_gap: busy fell after %0d want %0d", n, GAP); end
        vectors++; if (nw !== 1) begin miscompares++; $display("FAIL single_wrt_count: got %0d want 1", nw); end
    endtask

    task automatic test_round_robin();
        int wc[8], ac[8];
        logic [15:0] wd[8];
        logic [3:0] av[8];
        int nw, na, e;
        do_reset();
        req_data = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        req_w8 = 4'b0000; req_pos = 4'b0000; req = 4'b1111;
        nw = 0; na = 0;
        repeat (800) begin
            @(negedge clk);
            if (wrt && nw < 8) begin wc[nw] = cyc; wd[nw] = tx_data; nw++; end
            if (|ack && na < 8) begin ac[na] = cyc; av[na] = ack; na++; end
            if (na == 5) break;
        end
        req = 4'b0000;
        vectors++; if (na !== 5) begin miscompares++; $display("FAIL rr_ack_count: got %0d want 5", na); end
        for (int i = 0; i < 5 && i < na; i++) begin
            e = i % 4;
            vectors++; if (av[i] !== 4'(1 << e)) begin miscompares++; $display("FAIL rr_ack_order[%0d]: got %b want %b", i, av[i], 4'(1 << e)); end
            vectors++; if (wd[i] !== 16'(16'h1111 * (e + 1))) begin miscompares++; $display("FAIL rr_data[%0d]: got %h want %h", i, wd[i], 16'(16'h1111 * (e + 1))); end
        end
        for (int i = 1; i < 5 && i < na; i++) begin
            vectors++; if (wc[i] - ac[i-1] < int'(GAP + 2)) begin miscompares++; $display("FAIL rr_gap[%0d]: ack-to-wrt %0d want >= %0d", i, wc[i] - ac[i-1], GAP + 2); end
            vectors++; if (wc[i] - wc[i-1] < int'(GAP + 2)) begin miscompares++; $display("FAIL rr_spacing[%0d]: wrt-to-wrt %0d want >= %0d", i, wc[i] - wc[i-1], GAP + 2); end
        end
        wait_idle(100);
    endtask

    task automatic test_wrap();
        logic [3:0] a;
        logic [3:0] av[2];
        bit ok;
        int na;
        do_reset();
        req_data = {16'h4444, 16'h5555, 16'h2222, 16'h0A0A};
        req = 4'b0100;
        wait_ack(200, a, ok);
        req = 4'b0000;
        vectors++; if (!ok || a !== 4'b0100) begin miscompares++; $display("FAIL wrap_first: got %b want 0100", a); end
        wait_idle(100);
        req = 4'b0101;
        na = 0;
        repeat (400) begin
            @(negedge clk);
            if (|ack) begin
                if (na < 2) av[na] = ack;
                na++;
                req = req & ~ack;
            end
            if (na == 2) break;
        end
        req = 4'b0000;
        vectors++; if (na !== 2) begin miscompares++; $display("FAIL wrap_count: got %0d want 2", na); end
        vectors++; if (na >= 1 && av[0] !== 4'b0001) begin miscompares++; $display("FAIL wrap_order0: got %b want 0001", av[0]); end
        vectors++; if (na >= 2 && av[1] !== 4'b0100) begin miscompares++; $display("FAIL wrap_order1: got %b want 0100", av[1]); end
        wait_idle(100);
    endtask

    task automatic test_w8_drop();
        logic [3:0] a;
        bit ok;
        req_data[31:16] = 16'hCDAB; req_w8 = 4'b0010; req_pos = 4'b0000; req = 4'b0010;
        @(negedge clk);
        vectors++; if (width8 !== 1'b1) begin miscompares++; $display("FAIL w8_width8: got %b want 1", width8); end
        vectors++; if (tx_data !== 16'hCDAB) begin miscompares++; $display("FAIL w8_tx_data: got %h want cdab", tx_data); end
        vectors++; if (pos_edge !== 1'b0) begin miscompares++; $display("FAIL w8_pos_edge: got %b want 0", pos_edge); end
        @(negedge clk);
        vectors++; if (wrt !== 1'b1) begin miscompares++; $display("FAIL w8_wrt: got %b want 1", wrt); end
        req = 4'b0000;
        wait_ack(200, a, ok);
        vectors++; if (!ok || a !== 4'b0010) begin miscompares++; $display("FAIL w8_ack: got %b want 0010", a); end
        vectors++; if (last_frame !== 16'h00AB) begin miscompares++; $display("FAIL w8_frame: got %h want 00ab", last_frame); end
        req_w8 = 4'b0000;
        wait_idle(100);
    endtask

    task automatic test_reset_mid();
        logic [3:0] a;
        bit ok;
        int na;
        req_data[63:48] = 16'h5A5A; req_data[47:32] = 16'h6666; req = 4'b1000;
        repeat (20) begin @(negedge clk); if (wrt) break; end
        repeat (20) begin @(negedge clk); if (!done) break; end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++; if (wrt !== 1'b0) begin miscompares++; $display("FAIL mid_wrt: got %b want 0", wrt); end
        vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL mid_ack: got %b want 0000", ack); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL mid_busy: got %b want 0", busy); end
        vectors++; if (tx_data !== 16'h0000) begin miscompares++; $display("FAIL mid_tx_data: got %h want 0000", tx_data); end
        rst = 1'b0;
        req = 4'b0000;
        na = 0;
        repeat (40) begin
            @(negedge clk);
            if (|ack) na++;
        end
        vectors++; if (na !== 0) begin miscompares++; $display("FAIL mid_no_ack: got %0d acks want 0", na); end
        req = 4'b0100;
        wait_ack(200, a, ok);
        req = 4'b0000;
        vectors++; if (!ok || a !== 4'b0100) begin miscompares++; $display("FAIL mid_fresh_ack: got %b want 0100", a); end
        vectors++; if (last_frame !== 16'h6666) begin miscompares++; $display("FAIL mid_fresh_frame: got %h want 6666", last_frame); end
        wait_idle(100);
    endtask

    task automatic test_timeout();
        int na, ne, nw, ec;
        int wc[2];
        logic [15:0] wd[2];
        do_reset();
        req_data[15:0] = 16'h7777; req_data[31:16] = 16'h8888;
        force_low = 1'b1;
        @(negedge clk);
        req = 4'b0011;
        na = 0; ne = 0; nw = 0; ec = 0;
`ifdef SPI_ARB_TIMEOUT_EN
        repeat (400) begin
            @(negedge clk);
            if (wrt) begin
                if (nw < 2) begin wc[nw] = cyc; wd[nw] = tx_data; end
                nw++;
            end
            if (err) begin ne++; ec = cyc; end
            if (|ack) na++;
            if (nw == 2) break;
        end
        vectors++; if (nw !== 2) begin miscompares++; $display("FAIL tmo_regrant: got %0d wrts want 2", nw); end
        vectors++; if (ne !== 1) begin miscompares++; $display("FAIL tmo_err_count: got %0d want 1", ne); end
        vectors++; if (na !== 0) begin miscompares++; $display("FAIL tmo_no_ack: got %0d want 0", na); end
        vectors++; if (nw >= 1 && ec - wc[0] !== int'(TMO)) begin miscompares++; $display("FAIL tmo_err_time: got %0d want %0d", ec - wc[0], TMO); end
        vectors++; if (nw >= 2 && wd[1] !== 16'h7777) begin miscompares++; $display("FAIL tmo_same_req: got %h want 7777", wd[1]); end
`else
        repeat (300) begin
            @(negedge clk);
            if (err) ne++;
            if (|ack) na++;
        end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL tmo_busy: got %b want 1", busy); end
        vectors++; if (ne !== 0) begin miscompares++; $display("FAIL tmo_err: got %0d pulses want 0", ne); end
        vectors++; if (na !== 0) begin miscompares++; $display("FAIL tmo_no_ack: got %0d want 0", na); end
`endif
        req = 4'b0000;
        force_low = 1'b0;
        do_reset();
    endtask

    initial begin
        rst = 1'b1; req = '0; req_w8 = '0; req_pos = '0; req_data = '0;
        repeat (3) @(negedge clk);
        test_reset();
        test_single();
        wait_idle(100);
        test_round_robin();
        test_wrap();
        test_w8_drop();
        test_reset_mid();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
